// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV64 execute stage: ALU, iterative mul/div unit, EX/MEM register
// The mul/div datapath and its FSM are built only when EXEC_MULDIV_EN is defined.
module execute_stage #(
  parameter int XLEN      = 64,
  parameter int MD_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  logic            RegWriteEnE,
  input  logic            MemtoRegE,
  input  logic            JALE,
  input  logic            MemReadEnE,
  input  logic            MemWriteEnE,
  input  logic [1:0]      MemSizeE,
  input  logic [1:0]      LoadSizeE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] PcPlus4E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [XLEN-1:0] ReadData2E,
  input  logic [3:0]      ALUControlE,
  output logic            BusyE,
  output logic            RegWriteEnM,
  output logic            MemtoRegM,
  output logic            JALM,
  output logic            MemReadEnM,
  output logic            MemWriteEnM,
  output logic [1:0]      MemSizeM,
  output logic [1:0]      LoadSizeM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PcPlus4M,
  output logic [XLEN-1:0] ReadData2M,
  output logic [XLEN-1:0] ALUResultM
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;
  localparam int         SHAMT_W  = $clog2(XLEN);

  if (MD_CYCLES != XLEN) begin : g_cfg_check
    $error("execute_stage: MD_CYCLES must equal XLEN");
  end

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_result;
  logic [XLEN-1:0]    result;
  logic               capture;

  assign shamt = SrcBE[SHAMT_W-1:0];

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      OP_ADD:   alu_result = SrcAE + SrcBE;
      OP_SUB:   alu_result = SrcAE - SrcBE;
      OP_AND:   alu_result = SrcAE & SrcBE;
      OP_OR:    alu_result = SrcAE | SrcBE;
      OP_XOR:   alu_result = SrcAE ^ SrcBE;
      OP_SLL:   alu_result = SrcAE << shamt;
      OP_SRL:   alu_result = SrcAE >> shamt;
      OP_SRA:   alu_result = $signed(SrcAE) >>> shamt;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, SrcAE < SrcBE};
      OP_PASSB: alu_result = SrcBE;
      default:  alu_result = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;
  localparam int         CNT_W   = $clog2(MD_CYCLES);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, mcand_q, mplier_q, acc_q, quot_q, rem_q, div_q;
  logic [XLEN-1:0] a_mag, b_mag, md_result;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            busy, is_md, is_signed_div, start, div_ovf;

  assign is_md         = ALUControlE >= OP_MUL;
  assign is_signed_div = (ALUControlE == OP_DIV) || (ALUControlE == OP_REM);
  assign a_mag         = (is_signed_div && SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
  assign b_mag         = (is_signed_div && SrcBE[XLEN-1]) ? -SrcBE : SrcBE;
  assign start         = (state_q == IDLE) && is_md && !FlushE;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          busy = 1'b1;
          if (!FlushE) state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (FlushE) state_d = IDLE;
        else if (count_q == CNT_W'(MD_CYCLES - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BusyE = busy && !rst;

  // Restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, div_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      div_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        count_q  <= '0;
        op_q     <= ALUControlE;
        a_q      <= SrcAE;
        b_q      <= SrcBE;
        mcand_q  <= SrcAE;
        mplier_q <= SrcBE;
        acc_q    <= '0;
        quot_q   <= a_mag;
        div_q    <= b_mag;
        rem_q    <= '0;
      end else if (state_q == BUSY && !FlushE) begin
        count_q <= count_q + 1'b1;
        if (op_q == OP_MUL) begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end else if (!rem_diff[XLEN]) begin
          rem_q  <= rem_diff[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q  <= rem_shift[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], 1'b0};
        end
      end else begin
        count_q <= '0;
      end
    end
  end

  assign div_ovf = (a_q == MIN_NEG) && (b_q == '1);

  always_comb begin
    md_result = '0;
    case (op_q)
      OP_MUL:  md_result = acc_q;
      OP_DIV: begin
        if (b_q == '0)                         md_result = '1;
        else if (div_ovf)                      md_result = MIN_NEG;
        else if (a_q[XLEN-1] ^ b_q[XLEN-1])    md_result = -quot_q;
        else                                   md_result = quot_q;
      end
      OP_DIVU: md_result = (b_q == '0) ? '1 : quot_q;
      OP_REM: begin
        if (b_q == '0)        md_result = a_q;
        else if (div_ovf)     md_result = '0;
        else if (a_q[XLEN-1]) md_result = -rem_q;
        else                  md_result = rem_q;
      end
      OP_REMU: md_result = (b_q == '0) ? a_q : rem_q;
      default: md_result = '0;
    endcase
  end

  // ID/EX is held while busy, so the E fields in DONE still belong to the mul/div op.
  assign capture = !FlushE && (((state_q == IDLE) && !is_md) || (state_q == DONE));
  assign result  = (state_q == DONE) ? md_result : alu_result;
`else
  assign BusyE   = 1'b0;
  assign capture = !FlushE;
  assign result  = alu_result;
`endif

  always_ff @(posedge clk) begin
    if (rst || !capture) begin
      RegWriteEnM <= 1'b0;
      MemtoRegM   <= 1'b0;
      JALM        <= 1'b0;
      MemReadEnM  <= 1'b0;
      MemWriteEnM <= 1'b0;
      MemSizeM    <= '0;
      LoadSizeM   <= '0;
      RdM         <= '0;
      PcPlus4M    <= '0;
      ReadData2M  <= '0;
      ALUResultM  <= '0;
    end else begin
      RegWriteEnM <= RegWriteEnE;
      MemtoRegM   <= MemtoRegE;
      JALM        <= JALE;
      MemReadEnM  <= MemReadEnE;
      MemWriteEnM <= MemWriteEnE;
      MemSizeM    <= MemSizeE;
      LoadSizeM   <= LoadSizeE;
      RdM         <= RdE;
      PcPlus4M    <= PcPlus4E;
      ReadData2M  <= ReadData2E;
      ALUResultM  <= result;
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV64 execute stage: 64-bit ALU, iterative multiply/divide unit, and the EX/MEM pipeline register.
- Sits directly upstream of memory_stage; its registered outputs drive the memory_stage *M inputs one-to-one.
- Multi-cycle M-extension ops assert BusyE so that upstream stages hold while bubbles are inserted downstream.

Parameters:
XLEN, 64, datapath width; the only supported value is 64.
MD_CYCLES, 64, iterations per mul/div operation; must equal XLEN.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
FlushE  input  1  replace the current EX instruction with a bubble and abort any mul/div in progress
RegWriteEnE  input  1  register write enable from ID/EX
MemtoRegE  input  1  writeback source select
JALE  input  1  jump-and-link
MemReadEnE  input  1  load
MemWriteEnE  input  1  store
MemSizeE  input  2  store size: 00=B, 01=H, 10=W, 11=D
LoadSizeE  input  2  load size, same encoding as MemSizeE
RdE  input  5  destination register
PcPlus4E  input  64  PC+4 of the instruction
SrcAE  input  64  operand A, already forwarded
SrcBE  input  64  operand B, already forwarded and immediate-muxed
ReadData2E  input  64  store data, already forwarded
ALUControlE  input  4  operation select, encoding in Behaviour
BusyE  output  1  stall request to the PC, IF/ID and ID/EX registers
RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  output  1 each  registered control outputs
MemSizeM, LoadSizeM  output  2 each  registered size outputs
RdM  output  5  registered destination register
PcPlus4M, ReadData2M, ALUResultM  output  64 each  registered data outputs

Behaviour:
- Reset: all *M outputs are 0, the FSM is IDLE, the iteration counter is 0, and BusyE is 0.
- Priority on each clock edge: rst > FlushE > normal operation.
- ALUControlE encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcBE[5:0]
  - 1000 SLT (signed), 1001 SLTU; result is 0 or 1, zero-extended
  - 1010 PASSB (result = SrcBE)
  - 1011 MUL (low 64 bits), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
- Single-cycle ops (0000-1010): combinational result; all E fields plus the result are captured into the *M outputs on the next edge. Latency is 1 cycle. BusyE stays 0.
- ADD and SUB wrap modulo 2^64.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with a mul/div op present (ALUControlE >= 1011 and not suppressed by the Optional Feature):
    - BusyE = 1 combinationally.
    - On the edge: operands latched, counter cleared, state -> BUSY, bubble loaded into *M.
  - BUSY: lasts exactly MD_CYCLES cycles (counter 0..63). BusyE = 1. A bubble is loaded into *M every edge. After the count-63 edge, state -> DONE.
  - DONE: BusyE = 0. On this edge *M loads the held E control fields plus the mul/div result, and state -> IDLE. Upstream advances on the same edge.
  - A mul/div op therefore holds ID/EX for 65 cycles; the result appears on *M 66 edges after the op first appears.
- Bubble: every *M control and size field, RdM, PcPlus4M, ReadData2M and ALUResultM are 0.
- MUL: radix-2 shift-add; keeps the low 64 bits.
- DIV/REM: restoring division on operand magnitudes, then sign correction. The quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
- Forced results, applied in DONE:
  - Divide by zero: DIV and DIVU give all-ones; REM and REMU give the dividend.
  - Signed overflow (-2^63 / -1): DIV gives -2^63; REM gives 0.
- FlushE:
  - In IDLE or DONE: a bubble loads into *M and state -> IDLE.
  - In BUSY: the operation is aborted, state -> IDLE, counter cleared, bubble loaded into *M. BusyE is 0 in the following cycle.
- rst asserted mid-operation: same effect as reset; no partial result ever reaches *M.

Optional Feature:
- Macro: EXEC_MULDIV_EN.
- Defined: the mul/div unit and FSM are built as described above.
- Undefined:
  - No mul/div datapath or FSM is built; BusyE is tied to 0.
  - Codes 1011-1111 complete in 1 cycle with ALUResultM = 0 and all other fields passed through.

Test Plan:
- Reset: rst=1 for 2 cycles with random E inputs -> all *M outputs 0 and BusyE=0; then release with ADD, SrcAE=5, SrcBE=7, RdE=3, RegWriteEnE=1 -> next edge ALUResultM=12, RdM=3, RegWriteEnM=1.
- Store pass-through: ADD, SrcAE=0x20, SrcBE=0x10, MemWriteEnE=1, MemSizeE=01, ReadData2E=0xAABB -> ALUResultM=0x30, MemWriteEnM=1, MemSizeM=01, ReadData2M=0xAABB.
- Shifts: SRA with SrcAE=0x8000000000000000, SrcBE=0x43 -> ALUResultM=0xF000000000000000. SLTU with SrcAE=-1, SrcBE=1 -> ALUResultM=0.
- Multiply timing: MUL, SrcAE=0xFFFFFFFFFFFFFFFF, SrcBE=3 -> BusyE=1 for exactly 65 cycles and a bubble on *M for 65 edges; then ALUResultM=0xFFFFFFFFFFFFFFFD for 1 cycle.
- Divide corner cases:
  - DIV 0x8000000000000000 / -1 -> 0x8000000000000000.
  - REM -7 % 2 -> -1.
  - DIVU x / 0 -> 0xFFFFFFFFFFFFFFFF.
  - REMU 9 % 0 -> 9.
- Abort: FlushE at cycle 10 of a DIV -> BusyE=0 next cycle and *M holds a bubble. Repeat with rst instead of FlushE -> same outcome. A following ADD completes in 1 cycle.
